// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory streaming blocks.
//   rd_state_t   : reader FSM states
//   MIN_FIFO_OFF : skid FIFO must hold RD_LAT + MIN_FIFO_OFF entries
//   addr_w()     : address width for a given memory depth
package mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} rd_state_t;

  localparam int MIN_FIFO_OFF = 2;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/mem_stream_reader_if.sv
// Bundle of the reader's command, memory read port and output stream.
//   cmd_*        : command handshake {start address, word count}
//   enB/addrB    : memory read request, doutB : memory read data
//   m_*          : output word stream with last marker
//   busy/done    : status
// master = the reader, slave = its environment.
interface mem_stream_reader_if import mem_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
);
  localparam int AW = addr_w(DEPTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_addr;
  logic [AW:0]      cmd_len;
  logic             enB;
  logic [AW-1:0]    addrB;
  logic [WIDTH-1:0] doutB;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             busy;
  logic             done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, doutB, m_ready,
    output cmd_ready, enB, addrB, m_valid, m_data, m_last, busy, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, doutB, m_ready,
    input  cmd_ready, enB, addrB, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/sync_fifo_skid.sv
// Small synchronous FIFO with occupancy count, used to absorb memory read
// latency. Head entry is presented combinationally on head_o.
//   push_i/push_data_i : write strobe and data
//   pop_i              : consume head (ignored when empty)
//   head_o, empty_o    : head entry and empty flag
//   count_o            : registered occupancy
module sync_fifo_skid #(
  parameter  int W     = 33,
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          full, do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ptr_nxt(wr_q);
      end
      if (do_pop) rd_q <= ptr_nxt(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  // The upstream credit scheme must never push into a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && full && !pop_i));
endmodule

// File: rtl/mem_stream_reader.sv
// Read-side streamer for the dual-port memory wrapper. Takes a command
// {addr, len}, issues len reads on enB/addrB (wrapping modulo DEPTH), and
// streams doutB out on m_valid/m_ready with m_last on the final word.
//   clk, rst : clock, async active-high reset
//   bus      : master side of mem_stream_reader_if (command, read port,
//              output stream, busy/done)
module mem_stream_reader import mem_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = RD_LAT + MIN_FIFO_OFF
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stream_reader_if.master  bus
);
  localparam int AW = addr_w(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < RD_LAT + MIN_FIFO_OFF) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least RD_LAT+2");
  end

  rd_state_t         state_q;
  logic              cmd_ready_q, busy_q, done_q;
  logic [AW-1:0]     addr_q;
  logic [AW:0]       rem_q;
  logic [RD_LAT-1:0] pv_q, pl_q;   // in-flight {valid,last} per latency stage
  logic [CW-1:0]     inflight, fifo_cnt;
  logic [CW:0]       credit_sum;
  logic              issue, fifo_empty, pop, last_pop;
  logic [WIDTH:0]    head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pv_q[i]);
  end

  // Credit uses registered occupancy only: every outstanding read already
  // owns a FIFO slot, so the FIFO cannot overflow whatever m_ready does.
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign issue      = (state_q == ISSUE) && (rem_q != '0) &&
                      (credit_sum < (CW+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && bus.m_ready;
  assign last_pop   = pop && head[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      pv_q        <= '0;
      pl_q        <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          addr_q      <= bus.cmd_addr;
          rem_q       <= bus.cmd_len;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          // A zero-length command passes through the (already empty)
          // drain check, which places its done pulse two cycles later.
          state_q     <= (bus.cmd_len == '0) ? DRAIN : ISSUE;
        end
        ISSUE: if (issue && rem_q == (AW+1)'(1)) state_q <= DRAIN;
        DRAIN: if (last_pop || (inflight == '0 && fifo_empty)) begin
          state_q <= FINISH;
          done_q  <= 1'b1;
        end
        FINISH: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase

      if (issue) begin
        addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
        rem_q  <= rem_q - (AW+1)'(1);
      end

      pv_q[0] <= issue;
      pl_q[0] <= issue && (rem_q == (AW+1)'(1));
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
    end
  end

  // The exiting pipe stage lines up with doutB, so capture it directly.
  sync_fifo_skid #(.W(WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pv_q[RD_LAT-1]),
    .push_data_i ({pl_q[RD_LAT-1], bus.doutB}),
    .pop_i       (bus.m_ready),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.enB       = issue;
  assign bus.addrB     = addr_q;
  assign bus.m_valid   = !fifo_empty;
  assign bus.m_data    = head[WIDTH-1:0];
  assign bus.m_last    = head[WIDTH];
endmodule

// File: tb/tb_mem_stream_reader.sv
// Two readers (RD_LAT=1 and RD_LAT=2) share one stimulus stream; each has
// its own memory model and scoreboard checking every cycle.
module tb_mem_stream_reader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [AW-1:0]    cmd_addr  = '0;
  logic [AW:0]      cmd_len   = '0;
  logic             m_ready   = 1'b0;
  logic [WIDTH-1:0] mem [DEPTH];
  int               n_tests [2];
  int               n_fail  [2];

  always #5 clk = ~clk;

  for (genvar L = 0; L < 2; L++) begin : g_lane
    localparam int LAT = L + 1;
    localparam int FD  = LAT + 2;

    mem_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_addr  = cmd_addr;
    assign bus.cmd_len   = cmd_len;
    assign bus.m_ready   = m_ready;

    // Memory read port: stage 0 loads on enB, later stages always shift.
    // Not reset, so stale data survives a reader reset.
    logic [WIDTH-1:0] rp [LAT];
    always @(posedge clk) begin
      if (bus.enB) rp[0] <= mem[bus.addrB];
      for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end
    assign bus.doutB = rp[LAT-1];

    mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(LAT),
                        .FIFO_DEPTH(FD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic [WIDTH:0] exp_q [$];
    logic [WIDTH:0] ev, stall_val;
    logic [AW-1:0]  exp_addr;
    logic           exp_busy, exp_en, stall, all_ready;
    int cyc = 0, acc_cyc = -10, done_due = -5, rem = 0, issued = 0;
    int popped = 0, first_seen = 1, cmd_n = -1, wcnt = 0, cur_len = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
      n_tests[L]++;
      if (act !== exp) begin
        n_fail[L]++;
        $display("FAIL lat%0d %s: got 0x%0h expected 0x%0h (cycle %0d)",
                 LAT, nm, act, exp, cyc);
      end
    endtask

    initial forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst enB",       64'(bus.enB),       64'd0);
        chk("rst addrB",     64'(bus.addrB),     64'd0);
        chk("rst m_valid",   64'(bus.m_valid),   64'd0);
        chk("rst m_data",    64'(bus.m_data),    64'd0);
        chk("rst m_last",    64'(bus.m_last),    64'd0);
        chk("rst busy",      64'(bus.busy),      64'd0);
        chk("rst done",      64'(bus.done),      64'd0);
        exp_q.delete();
        acc_cyc = -10; done_due = -5; rem = 0; issued = 0; popped = 0;
        stall = 1'b0; first_seen = 1;
      end else begin
        exp_busy = (cyc > acc_cyc) && (cyc <= done_due);
        chk("busy",      64'(bus.busy),      64'(exp_busy));
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(!exp_busy));
        chk("done",      64'(bus.done),      64'(cyc == done_due));
        exp_en = exp_busy && (rem > 0) && (issued - popped < FD);
        chk("enB", 64'(bus.enB), 64'(exp_en));
        if (bus.enB) begin
          chk("addrB", 64'(bus.addrB), 64'(exp_addr));
          exp_addr = (exp_addr == AW'(DEPTH - 1)) ? '0 : exp_addr + 1'b1;
          rem--; issued++;
        end
        if (stall) begin
          chk("stall m_valid", 64'(bus.m_valid), 64'd1);
          chk("stall word", 64'({bus.m_last, bus.m_data}), 64'(stall_val));
        end
        if (!bus.m_ready) all_ready = 1'b0;
        if (bus.m_valid && first_seen == 0) begin
          chk("first valid latency", 64'(cyc - acc_cyc), 64'(LAT + 2));
          first_seen = 1;
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            n_tests[L]++; n_fail[L]++;
            $display("FAIL lat%0d extra word: got 0x%0h expected none (cycle %0d)",
                     LAT, bus.m_data, cyc);
          end else begin
            ev = exp_q.pop_front();
            chk("m_data", 64'(bus.m_data), 64'(ev[WIDTH-1:0]));
            chk("m_last", 64'(bus.m_last), 64'(ev[WIDTH]));
            if (cmd_n == 0)
              chk("basic literal", 64'(bus.m_data), 64'(32'h104 + wcnt));
            wcnt++; popped++;
            if (ev[WIDTH]) begin
              done_due = cyc + 1;
              if (all_ready)
                chk("no bubbles", 64'(cyc - acc_cyc), 64'(LAT + 2 + cur_len - 1));
            end
          end
        end
        stall     = bus.m_valid && !bus.m_ready;
        stall_val = {bus.m_last, bus.m_data};
        if (bus.cmd_valid && bus.cmd_ready) begin
          cmd_n++; acc_cyc = cyc; cur_len = int'(bus.cmd_len);
          rem = cur_len; exp_addr = bus.cmd_addr; wcnt = 0;
          first_seen = (cur_len == 0); all_ready = 1'b1;
          done_due = (cur_len == 0) ? cyc + 2 : 1 << 30;
          for (int i = 0; i < cur_len; i++)
            exp_q.push_back({(i == cur_len - 1),
                             mem[(int'(bus.cmd_addr) + i) % DEPTH]});
        end
      end
    end
  end

  function automatic logic both_idle();
    return g_lane[0].bus.cmd_ready && g_lane[1].bus.cmd_ready;
  endfunction

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return (k >= 6 && k < 16) ? 1'b0 : (k % 2 == 0);
    endcase
  endfunction

  task automatic wait_idle(input int mode);
    int k = 0;
    while (!both_idle()) begin
      m_ready = ready_for(mode, k);
      @(posedge clk); #1;
      k++;
      if (k > 5000) begin
        $display("FAIL timeout: readers still busy after %0d cycles", k);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic start(input int a, input int n);
    wait_idle(0);
    cmd_valid = 1'b1;
    cmd_addr  = AW'(a);
    cmd_len   = (AW+1)'(n);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run(input int a, input int n, input int mode);
    start(a, n);
    wait_idle(mode);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 'h100);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run(4, 3, 0);      // basic read
    run(510, 4, 0);    // wrap-around
    run(20, 16, 2);    // backpressure with long low stretch
    run(7, 0, 0);      // zero length
    run(100, 512, 0);  // full length
    repeat (30)
      run($urandom_range(0, DEPTH - 1), $urandom_range(0, 40),
          $urandom_range(0, 2));

    // Reset in the middle of a command, asserted away from a clock edge.
    m_ready = 1'b1;
    start(50, 20);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(0, 2, 0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed",
             n_tests[0] + n_tests[1], n_fail[0] + n_fail[1]);
    $finish;
  end
endmodule
